// File: rtl/mem_copy_engine.sv
// Bus-master copy engine for one 8-bit data bank: forward byte copy Src->Dst
// of Length bytes through the bank port, with a modulo-2^SUM_W byte sum.
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W:0]   Length,
    output logic              Busy,
    output logic              Done,
    output logic [SUM_W-1:0]  Sum,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [SUM_W-1:0]  SUM_ZERO  = {SUM_W{1'b0}};

    state_t            r_state;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_data;
    logic [SUM_W-1:0]  r_sum;
    logic [ADDR_W-1:0] r_address;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_busy;
    logic              r_done;
    logic [SUM_W-1:0]  w_read_ext;

    // Zero-extended read byte for the running sum.
    assign w_read_ext = {{(SUM_W-DATA_W){1'b0}}, ReadData};

    // Bus controls are computed one state ahead so every output is a flop
    // that already holds the value belonging to the state being entered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_src_ptr   <= ADDR_ZERO;
            r_dst_ptr   <= ADDR_ZERO;
            r_count     <= CNT_ZERO;
            r_data      <= DATA_ZERO;
            r_sum       <= SUM_ZERO;
            r_address   <= ADDR_ZERO;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mem_write <= 1'b0;
                    if (Start) begin
                        r_src_ptr <= SrcAddr;
                        r_dst_ptr <= DstAddr;
                        r_count   <= Length;
                        r_sum     <= SUM_ZERO;
                        if (Length == CNT_ZERO) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_mem_read <= 1'b0;
                            r_address  <= ADDR_ZERO;
                        end else begin
                            r_state    <= S_READ;
                            r_done     <= 1'b0;
                            r_busy     <= 1'b1;
                            r_mem_read <= 1'b1;
                            r_address  <= SrcAddr;
                        end
                    end else begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b0;
                        r_mem_read <= 1'b0;
                        r_address  <= ADDR_ZERO;
                    end
                end
                S_READ: begin
                    r_data      <= ReadData;
                    r_sum       <= r_sum + w_read_ext;
                    r_src_ptr   <= r_src_ptr + ADDR_ONE;
                    r_state     <= S_WRITE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b1;
                    r_address   <= r_dst_ptr;
                    r_busy      <= 1'b1;
                    r_done      <= 1'b0;
                end
                S_WRITE: begin
                    r_dst_ptr   <= r_dst_ptr + ADDR_ONE;
                    r_count     <= r_count - CNT_ONE;
                    r_mem_write <= 1'b0;
                    // r_count still holds the pre-decrement value here.
                    if (r_count != CNT_ONE) begin
                        r_state    <= S_READ;
                        r_mem_read <= 1'b1;
                        r_address  <= r_src_ptr;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end else begin
                        r_state    <= S_DONE;
                        r_mem_read <= 1'b0;
                        r_address  <= ADDR_ZERO;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_address   <= ADDR_ZERO;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_address   <= ADDR_ZERO;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from flops; WriteData is the data latch itself.
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Sum       = r_sum;
    assign Address   = r_address;
    assign WriteData = r_data;
    assign MemWrite  = r_mem_write;
    assign MemRead   = r_mem_read;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a behavioural bank plus a forward-copy
// reference model feeding expected writes and completions to a monitor.
module tb_mem_copy_engine;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] SrcAddr = 8'h00;
    logic [7:0] DstAddr = 8'h00;
    logic [8:0] Length = 9'd0;
    logic       Busy, Done, MemWrite, MemRead;
    logic [15:0] Sum;
    logic [7:0] Address, WriteData, ReadData;

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .SUM_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .SrcAddr(SrcAddr),
        .DstAddr(DstAddr), .Length(Length), .Busy(Busy), .Done(Done),
        .Sum(Sum), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [256];
    logic [7:0] init_mem [256];
    logic [7:0] ref_mem [256];
    logic       load_req = 1'b0;

    assign ReadData = MemRead ? mem[Address] : 8'h00;

    always @(posedge Clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        end else if (MemWrite) begin
            mem[Address] <= WriteData;
        end
    end

    typedef struct { logic [15:0] sum; int cyc; int busy; } exp_t;
    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge and pops the scoreboard queues.
    always @(negedge Clk) begin
        exp_t e;
        wr_t  w;
        cyc = cyc + 1;
        if (!Rst_n) begin
            busy_cnt = 0;
        end else begin
            if (MemRead && MemWrite) check("rw_exclusive", 64'd1, 64'd0);
            if (!MemRead && !MemWrite && Address != 8'h00)
                check("idle_address", 64'(Address), 64'd0);
            if (Busy) busy_cnt = busy_cnt + 1;
            if (MemWrite) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 64'(Address), 64'hFFFF);
                end else begin
                    w = wr_q.pop_front();
                    check("write_addr", 64'(Address), 64'(w.a));
                    check("write_data", 64'(WriteData), 64'(w.d));
                end
            end
            if (Done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_sum", 64'(Sum), 64'(e.sum));
                    check("done_latency", 64'(cyc), 64'(e.cyc));
                    check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                    if (Busy) check("busy_in_done", 64'd1, 64'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic load_bank(input int kind);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                0:       init_mem[i] = 8'(i);
                1:       init_mem[i] = 8'hFF;
                default: init_mem[i] = 8'($urandom);
            endcase
            ref_mem[i] = init_mem[i];
        end
        @(negedge Clk); #1;
        load_req = 1'b1;
        @(negedge Clk); #1;
        load_req = 1'b0;
    endtask

    // Reference: plain ascending byte copy; only the first nwr writes land.
    task automatic issue(input logic [7:0] s, input logic [7:0] d, input int len,
                         input bit exp_done, input int nwr);
        logic [15:0] sum;
        logic [7:0]  b, sa, da;
        sum = 16'h0000;
        @(negedge Clk); #1;
        for (int i = 0; i < len; i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            b = ref_mem[sa];
            sum = sum + {8'h00, b};
            if (i < nwr) begin
                wr_q.push_back('{a: da, d: b});
                ref_mem[da] = b;
            end
        end
        if (exp_done) exp_q.push_back('{sum: sum, cyc: cyc + 2 * len + 1, busy: 2 * len});
        Start = 1'b1; SrcAddr = s; DstAddr = d; Length = 9'(len);
        @(negedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("completion_timeout", 64'(exp_q.size() + wr_q.size()), 64'd0);
        exp_q.delete();
        wr_q.delete();
        repeat (2) @(negedge Clk);
        #1;
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 256; i++)
            if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
        check(name, 64'(bad), 64'(-1));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({Busy, Done, Sum, Address, WriteData, MemWrite, MemRead});
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        repeat (3) @(negedge Clk);
        #1 Rst_n = 1'b1;

        load_bank(0);
        issue(8'h10, 8'h80, 4, 1'b1, 4);
        wait_idle(100);
        check("tp_basic_sum", 64'(Sum), 64'h0046);
        check_mem("tp_basic_mem");

        issue(8'h05, 8'h06, 0, 1'b1, 0);
        wait_idle(20);
        check("tp_len0_sum", 64'(Sum), 64'h0000);
        check_mem("tp_len0_mem");

        load_bank(0);
        issue(8'hFE, 8'h01, 3, 1'b1, 3);
        wait_idle(100);
        check("tp_wrap_sum", 64'(Sum), 64'h01FD);
        check_mem("tp_wrap_mem");

        load_bank(2);
        init_mem[8'h20] = 8'hAA;
        ref_mem[8'h20] = 8'hAA;
        @(negedge Clk); #1 load_req = 1'b1;
        @(negedge Clk); #1 load_req = 1'b0;
        issue(8'h20, 8'h21, 3, 1'b1, 3);
        wait_idle(100);
        check("tp_overlap_byte", 64'(mem[8'h23]), 64'hAA);
        check_mem("tp_overlap_mem");

        load_bank(1);
        issue(8'h00, 8'h00, 256, 1'b1, 256);
        wait_idle(1000);
        check("tp_full_sum", 64'(Sum), 64'hFF00);
        check_mem("tp_full_mem");

        // Reset after the second write of a five-byte copy, with a stray Start.
        load_bank(2);
        issue(8'h40, 8'h90, 5, 1'b0, 2);
        @(negedge Clk); #1 Start = 1'b1;
        @(negedge Clk); #1 Start = 1'b0;
        @(negedge Clk); #1;
        @(negedge Clk); #1 Rst_n = 1'b0;
        #1 check("midreset_outputs", all_outs(), 64'd0);
        repeat (2) @(negedge Clk);
        #1 check("midreset_held", all_outs(), 64'd0);
        Rst_n = 1'b1;
        check("midreset_writes", 64'(wr_q.size()), 64'd0);
        check_mem("midreset_mem");
        issue(8'h40, 8'h90, 5, 1'b1, 5);
        wait_idle(100);
        check_mem("after_reset_mem");

        for (int t = 0; t < 12; t++) begin
            int len;
            if (t % 4 == 0) load_bank(2);
            len = (t == 5) ? 0 : int'($urandom_range(1, 40));
            issue(8'($urandom), 8'($urandom), len, 1'b1, len);
            wait_idle(200);
            check_mem("random_mem");
        end

        check("leftover_queues", 64'(exp_q.size() + wr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
